// File: rtl/id_stage.sv
// Decode stage: register file, branch/jump resolution, load-use hazard
// detection and the ID/EX pipeline register.
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt_in,
    output logic        hold_pc,
    output logic        hold_if,
    output logic        br,
    output logic [31:0] pc_branch,
    output logic        except,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [5:0]  ex_opcode,
    output logic [5:0]  ex_funct
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  opcode;
        logic [5:0]  funct;
    } id_ex_t;

    localparam id_ex_t ID_EX_RESET = '{pc: RESET_PC, default: '0};

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        unused_shamt;

    assign opcode       = inst_in[31:26];
    assign rs           = inst_in[25:21];
    assign rt           = inst_in[20:16];
    assign rd           = inst_in[15:11];
    assign funct        = inst_in[5:0];
    assign imm          = inst_in[15:0];
    assign target       = inst_in[25:0];
    assign unused_shamt = ^inst_in[10:6];

    logic [31:0] rf_q [32];
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    // Write-through lets a value retiring this cycle reach decode directly.
    assign rs_data = (rs == 5'd0) ? 32'h0 :
                     (wb_en && wb_addr == rs) ? wb_data : rf_q[rs];
    assign rt_data = (rt == 5'd0) ? 32'h0 :
                     (wb_en && wb_addr == rt) ? wb_data : rf_q[rt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en && wb_addr != 5'd0) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    logic legal;

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LW, OP_SW: legal = 1'b1;
            default:      legal = 1'b0;
        endcase
    end

    logic is_jal;
    logic is_jump;
    logic is_beq;
    logic is_bne;
    logic is_zext;
    logic is_lui;
    logic stall;
    logic bubble;

    assign is_jal  = (opcode == OP_JAL);
    assign is_jump = (opcode == OP_J) || is_jal;
    assign is_beq  = (opcode == OP_BEQ);
    assign is_bne  = (opcode == OP_BNE);
    assign is_zext = (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                     (opcode == OP_XORI);
    assign is_lui  = (opcode == OP_LUI);

    assign stall  = ex_mem_read && (ex_rt_in != 5'd0) &&
                    ((ex_rt_in == rs) || (ex_rt_in == rt));
    assign bubble = stall || !legal;

    assign hold_pc = stall;
    assign hold_if = stall;
    assign except  = !legal && !stall;

    logic [31:0] imm_sext;
    logic [31:0] br_target;
    logic [31:0] jmp_target;

    assign imm_sext   = {{16{imm[15]}}, imm};
    assign br_target  = pc_in + {imm_sext[29:0], 2'b00};
    assign jmp_target = {pc_in[31:28], target, 2'b00};

    // A stalled instruction must not redirect fetch; it resolves next cycle.
    always_comb begin
        br        = 1'b0;
        pc_branch = 32'h0;
        if (!stall) begin
            unique case (1'b1)
                is_beq: begin
                    br        = (rs_data == rt_data);
                    pc_branch = br_target;
                end
                is_bne: begin
                    br        = (rs_data != rt_data);
                    pc_branch = br_target;
                end
                is_jump: begin
                    br        = 1'b1;
                    pc_branch = jmp_target;
                end
                default: ;
            endcase
        end
    end

    logic [31:0] imm_ext;
    logic [4:0]  dest;

    always_comb begin
        imm_ext = imm_sext;
        unique case (1'b1)
            is_jal:  imm_ext = pc_in + 32'd4;
            is_zext: imm_ext = {16'h0, imm};
            is_lui:  imm_ext = {imm, 16'h0};
            default: ;
        endcase
    end

    always_comb begin
        dest = rt;
        unique case (1'b1)
            is_jal:                dest = 5'd31;
            (opcode == OP_RTYPE):  dest = rd;
            default: ;
        endcase
    end

    id_ex_t id_ex_d;
    id_ex_t id_ex_q;

    always_comb begin
        id_ex_d = '0;
        if (!bubble) begin
            id_ex_d.valid   = 1'b1;
            id_ex_d.pc      = pc_in;
            id_ex_d.rs_data = rs_data;
            id_ex_d.rt_data = rt_data;
            id_ex_d.imm     = imm_ext;
            id_ex_d.rs      = rs;
            id_ex_d.rt      = rt;
            id_ex_d.rd      = dest;
            id_ex_d.opcode  = opcode;
            id_ex_d.funct   = funct;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_q <= ID_EX_RESET;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ex_valid   = id_ex_q.valid;
    assign ex_pc      = id_ex_q.pc;
    assign ex_rs_data = id_ex_q.rs_data;
    assign ex_rt_data = id_ex_q.rt_data;
    assign ex_imm     = id_ex_q.imm;
    assign ex_rs      = id_ex_q.rs;
    assign ex_rt      = id_ex_q.rt;
    assign ex_rd      = id_ex_q.rd;
    assign ex_opcode  = id_ex_q.opcode;
    assign ex_funct   = id_ex_q.funct;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios plus randomized decode
// checked against a behavioural model of the decode rules.
module tb_id_stage;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic [31:0] inst_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rt_in;
    logic        hold_pc;
    logic        hold_if;
    logic        br;
    logic [31:0] pc_branch;
    logic        except;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [32];

    always #5 clk = ~clk;

    id_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .inst_in(inst_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_rt_in(ex_rt_in),
        .hold_pc(hold_pc), .hold_if(hold_if), .br(br),
        .pc_branch(pc_branch), .except(except), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct)
    );

    typedef struct {
        logic        hold;
        logic        br;
        logic [31:0] pcb;
        logic        exc;
        logic        v;
        logic [31:0] pc;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  op;
        logic [5:0]  fn;
    } exp_t;

    function automatic logic [31:0] rdm(input logic [4:0] i);
        if (i == 0) return 32'h0;
        if (wb_en && wb_addr == i) return wb_data;
        return mdl[i];
    endfunction

    function automatic exp_t model();
        exp_t e;
        int op, rs, rt, rd;
        logic stall, legal;
        logic [31:0] a, b, sx;
        e = '{default: '0};
        op = int'(inst_in[31:26]);
        rs = int'(inst_in[25:21]);
        rt = int'(inst_in[20:16]);
        rd = int'(inst_in[15:11]);
        stall = ex_mem_read && ex_rt_in != 0 &&
                (int'(ex_rt_in) == rs || int'(ex_rt_in) == rt);
        legal = op == 0 || op == 2 || op == 3 || op == 4 || op == 5 ||
                (op >= 8 && op <= 15) || op == 35 || op == 43;
        a = rdm(5'(rs));
        b = rdm(5'(rt));
        sx = 32'($signed(inst_in[15:0]));
        e.hold = stall;
        e.exc = !legal && !stall;
        if (!stall) begin
            if (op == 4) begin e.br = (a == b); e.pcb = pc_in + sx * 4; end
            if (op == 5) begin e.br = (a != b); e.pcb = pc_in + sx * 4; end
            if (op == 2 || op == 3) begin
                e.br = 1'b1;
                e.pcb = {pc_in[31:28], inst_in[25:0], 2'b00};
            end
        end
        if (!stall && legal) begin
            e.v = 1'b1;
            e.pc = pc_in;
            e.rsd = a;
            e.rtd = b;
            if (op == 3) e.imm = pc_in + 4;
            else if (op >= 12 && op <= 14) e.imm = {16'h0, inst_in[15:0]};
            else if (op == 15) e.imm = {inst_in[15:0], 16'h0};
            else e.imm = sx;
            e.rs = 5'(rs);
            e.rt = 5'(rt);
            e.rd = (op == 3) ? 5'd31 : (op == 0) ? 5'(rd) : 5'(rt);
            e.op = 6'(op);
            e.fn = inst_in[5:0];
        end
        return e;
    endfunction

    function automatic logic [31:0] rtype(input int s, t, d, f);
        return {6'h0, 5'(s), 5'(t), 5'(d), 5'h0, 6'(f)};
    endfunction

    function automatic logic [31:0] itype(input int o, s, t, input logic [15:0] im);
        return {6'(o), 5'(s), 5'(t), im};
    endfunction

    task automatic drive(input logic [31:0] i, p, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic mr, input logic [4:0] rti);
        @(negedge clk);
        inst_in = i; pc_in = p; wb_en = we; wb_addr = wa; wb_data = wd;
        ex_mem_read = mr; ex_rt_in = rti;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (wb_en && wb_addr != 0) mdl[wb_addr] = wb_data;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        inst_in = '0; pc_in = '0; wb_en = 0; wb_addr = '0; wb_data = '0;
        ex_mem_read = 0; ex_rt_in = '0;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ex_valid !== 1'b0 || ex_pc !== RPC || ex_imm !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: valid=%b pc=%h imm=%h want 0 %h 0",
                     ex_valid, ex_pc, ex_imm, RPC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(rtype(31, 30, 3, 32'h20), 32'h40, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_rs_data !== 0 || ex_rt_data !== 0) begin
            fails++;
            $display("FAIL reset_reads: valid=%b rs=%h rt=%h want 1 0 0",
                     ex_valid, ex_rs_data, ex_rt_data);
        end
    endtask

    task automatic test_writeback();
        drive(32'h0, 32'h44, 1, 5, 32'h1234_5678, 0, 0);
        tick();
        drive(rtype(5, 0, 3, 32'h20), 32'h48, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (ex_rs_data !== 32'h1234_5678 || ex_rd !== 5'd3 || ex_pc !== 32'h48) begin
            fails++;
            $display("FAIL writeback: rs_data=%h rd=%0d pc=%h want 12345678 3 48",
                     ex_rs_data, ex_rd, ex_pc);
        end
    endtask

    task automatic test_writethrough();
        drive(rtype(8, 0, 1, 32'h25), 32'h50, 1, 8, 32'hAA, 0, 0);
        tick();
        tests++;
        if (ex_rs_data !== 32'hAA) begin
            fails++;
            $display("FAIL write_through: got %h want 000000aa", ex_rs_data);
        end
        drive(rtype(0, 0, 1, 32'h25), 32'h54, 1, 0, 32'hFFFF, 0, 0);
        tick();
        drive(rtype(0, 8, 1, 32'h25), 32'h58, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (ex_rs_data !== 32'h0 || ex_rt_data !== 32'hAA) begin
            fails++;
            $display("FAIL r0_write: rs=%h rt=%h want 0 aa", ex_rs_data, ex_rt_data);
        end
    endtask

    task automatic test_load_use();
        drive(rtype(9, 1, 2, 32'h20), 32'h60, 0, 0, 0, 1, 9);
        tests++;
        if (hold_pc !== 1'b1 || hold_if !== 1'b1) begin
            fails++;
            $display("FAIL load_use_hold: pc=%b if=%b want 1 1", hold_pc, hold_if);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_rd !== 5'd0) begin
            fails++;
            $display("FAIL load_use_bubble: valid=%b pc=%h rd=%0d want 0 0 0",
                     ex_valid, ex_pc, ex_rd);
        end
        drive(rtype(9, 1, 2, 32'h20), 32'h60, 0, 0, 0, 0, 0);
        tests++;
        if (hold_pc !== 1'b0 || hold_if !== 1'b0) begin
            fails++;
            $display("FAIL load_use_release: pc=%b if=%b want 0 0", hold_pc, hold_if);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd2 || ex_pc !== 32'h60) begin
            fails++;
            $display("FAIL load_use_issue: valid=%b rd=%0d pc=%h want 1 2 60",
                     ex_valid, ex_rd, ex_pc);
        end
    endtask

    task automatic test_beq();
        drive(32'h0, 32'h70, 1, 1, 32'd7, 0, 0); tick();
        drive(32'h0, 32'h74, 1, 2, 32'd7, 0, 0); tick();
        drive(itype(4, 1, 2, 16'hFFFE), 32'h100, 0, 0, 0, 0, 0);
        tests++;
        if (br !== 1'b1 || pc_branch !== 32'h0F8) begin
            fails++;
            $display("FAIL beq_taken: br=%b tgt=%h want 1 000000f8", br, pc_branch);
        end
        tick();
        tests++;
        if (ex_imm !== 32'hFFFF_FFFE || ex_rd !== 5'd2) begin
            fails++;
            $display("FAIL beq_idex: imm=%h rd=%0d want fffffffe 2", ex_imm, ex_rd);
        end
        drive(32'h0, 32'h104, 1, 2, 32'd8, 0, 0); tick();
        drive(itype(4, 1, 2, 16'hFFFE), 32'h100, 0, 0, 0, 0, 0);
        tests++;
        if (br !== 1'b0) begin
            fails++;
            $display("FAIL beq_not_taken: br=%b want 0", br);
        end
        drive(itype(4, 1, 2, 16'h0010), 32'h200, 1, 2, 32'd7, 0, 0);
        tests++;
        if (br !== 1'b1 || pc_branch !== 32'h240) begin
            fails++;
            $display("FAIL beq_bypass: br=%b tgt=%h want 1 00000240", br, pc_branch);
        end
        tick();
        drive(itype(4, 1, 2, 16'h0010), 32'h200, 0, 0, 0, 1, 2);
        tests++;
        if (br !== 1'b0 || hold_pc !== 1'b1) begin
            fails++;
            $display("FAIL beq_stall: br=%b hold=%b want 0 1", br, hold_pc);
        end
        tick();
    endtask

    task automatic test_jal_ext();
        drive({6'h03, 26'h40}, 32'h1000_0004, 0, 0, 0, 0, 0);
        tests++;
        if (br !== 1'b1 || pc_branch !== 32'h1000_0100) begin
            fails++;
            $display("FAIL jal_target: br=%b tgt=%h want 1 10000100", br, pc_branch);
        end
        tick();
        tests++;
        if (ex_rd !== 5'd31 || ex_imm !== 32'h1000_0008) begin
            fails++;
            $display("FAIL jal_link: rd=%0d imm=%h want 31 10000008", ex_rd, ex_imm);
        end
        drive(itype(6'h0D, 0, 4, 16'h8000), 32'h300, 0, 0, 0, 0, 0); tick();
        tests++;
        if (ex_imm !== 32'h0000_8000 || ex_rd !== 5'd4) begin
            fails++;
            $display("FAIL ori_zext: imm=%h rd=%0d want 00008000 4", ex_imm, ex_rd);
        end
        drive(itype(6'h08, 0, 4, 16'h8000), 32'h304, 0, 0, 0, 0, 0); tick();
        tests++;
        if (ex_imm !== 32'hFFFF_8000) begin
            fails++;
            $display("FAIL addi_sext: imm=%h want ffff8000", ex_imm);
        end
        drive(itype(6'h0F, 0, 4, 16'h1234), 32'h308, 0, 0, 0, 0, 0); tick();
        tests++;
        if (ex_imm !== 32'h1234_0000) begin
            fails++;
            $display("FAIL lui: imm=%h want 12340000", ex_imm);
        end
    endtask

    task automatic test_illegal();
        drive(itype(6'h3F, 3, 4, 16'h1234), 32'h400, 0, 0, 0, 0, 0);
        tests++;
        if (except !== 1'b1) begin
            fails++;
            $display("FAIL illegal_except: got %b want 1", except);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b0 || ex_opcode !== 6'h0) begin
            fails++;
            $display("FAIL illegal_bubble: valid=%b op=%h want 0 0", ex_valid, ex_opcode);
        end
        drive(itype(6'h3F, 3, 4, 16'h1234), 32'h400, 0, 0, 0, 1, 3);
        tests++;
        if (except !== 1'b0 || hold_if !== 1'b1) begin
            fails++;
            $display("FAIL illegal_stall: except=%b hold=%b want 0 1", except, hold_if);
        end
        tick();
        drive(32'h0, 32'h404, 0, 0, 0, 0, 0); tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd0 || except !== 1'b0) begin
            fails++;
            $display("FAIL nop: valid=%b rd=%0d except=%b want 1 0 0",
                     ex_valid, ex_rd, except);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h01,
                                 6'h3F, 6'h20};
        exp_t e;
        logic [31:0] ins;
        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 19)];
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            drive(ins, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
            e = model();
            tests++;
            if ({hold_pc, hold_if, br, except, pc_branch} !==
                {e.hold, e.hold, e.br, e.exc, e.pcb}) begin
                fails++;
                $display("FAIL rand_comb inst=%h: hold=%b/%b br=%b exc=%b tgt=%h want %b %b %b %h",
                         ins, hold_pc, hold_if, br, except, pc_branch,
                         e.hold, e.br, e.exc, e.pcb);
            end
            tick();
            tests++;
            if ({ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm, ex_rs,
                 ex_rt, ex_rd, ex_opcode, ex_funct} !==
                {e.v, e.pc, e.rsd, e.rtd, e.imm, e.rs, e.rt, e.rd, e.op, e.fn}) begin
                fails++;
                $display("FAIL rand_idex inst=%h: v=%b pc=%h rs=%h rt=%h imm=%h rd=%0d want v=%b pc=%h rs=%h rt=%h imm=%h rd=%0d",
                         ins, ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
                         ex_rd, e.v, e.pc, e.rsd, e.rtd, e.imm, e.rd);
            end
        end
    endtask

    task automatic test_reset_midstall();
        drive(32'h0, 32'h500, 1, 1, 32'd7, 0, 0); tick();
        drive(rtype(9, 1, 2, 32'h20), 32'h504, 0, 0, 0, 1, 9);
        tests++;
        if (hold_pc !== 1'b1 || ex_pc !== 32'h500) begin
            fails++;
            $display("FAIL pre_reset_stall: hold=%b pc=%h want 1 500", hold_pc, ex_pc);
        end
        rst_n = 1'b0;
        ex_mem_read = 1'b0;
        ex_rt_in = 5'd0;
        #1;
        tests++;
        if (hold_pc !== 1'b0 || hold_if !== 1'b0 || ex_valid !== 1'b0 ||
            ex_pc !== RPC || ex_rd !== 5'd0) begin
            fails++;
            $display("FAIL midstall_reset: hold=%b/%b valid=%b pc=%h rd=%0d want 0 0 0 %h 0",
                     hold_pc, hold_if, ex_valid, ex_pc, ex_rd, RPC);
        end
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(rtype(1, 5, 2, 32'h20), 32'h508, 0, 0, 0, 0, 0); tick();
        tests++;
        if (ex_rs_data !== 32'h0 || ex_rt_data !== 32'h0 || ex_valid !== 1'b1) begin
            fails++;
            $display("FAIL regfile_cleared: rs=%h rt=%h valid=%b want 0 0 1",
                     ex_rs_data, ex_rt_data, ex_valid);
        end
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_writethrough();
        test_load_use();
        test_beq();
        test_jal_ext();
        test_illegal();
        test_random();
        test_reset_midstall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the MIPS R2000 pipeline, directly downstream of the fetch stage. It consumes the fetch stage's registered `pc_out` and `inst_out`, and holds the 32×32 register file. It resolves branches and jumps in decode and drives `br`/`pc_branch` back to the fetch mux. It also detects load-use hazards, driving `hold_pc`/`hold_if` and inserting bubbles, and registers the decoded operands into the ID/EX pipeline register.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: value loaded into `ex_pc` on reset.

Ports:
- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pc_in`  in  32  address of `inst_in` + 4, from fetch.
- `inst_in`  in  32  instruction from fetch.
- `wb_en`  in  1  write-back enable.
- `wb_addr`  in  5  write-back register index.
- `wb_data`  in  32  write-back value.
- `ex_mem_read`  in  1  instruction currently in EX is a load.
- `ex_rt_in`  in  5  destination register (rt) of that load.
- `hold_pc`  out  1  freeze the PC register (comb).
- `hold_if`  out  1  freeze the IF/ID register (comb).
- `br`  out  1  redirect fetch to `pc_branch` (comb).
- `pc_branch`  out  32  branch/jump target (comb).
- `except`  out  1  reserved-instruction exception (comb).
- `ex_valid`  out  1  ID/EX holds a real instruction.
- `ex_pc`  out  32  registered `pc_in`.
- `ex_rs_data`  out  32  registered rs operand.
- `ex_rt_data`  out  32  registered rt operand.
- `ex_imm`  out  32  registered extended immediate.
- `ex_rs`  out  5  registered rs index.
- `ex_rt`  out  5  registered rt index.
- `ex_rd`  out  5  registered rd index.
- `ex_opcode`  out  6  registered opcode.
- `ex_funct`  out  6  registered funct.

## Operation
- Field split:
  - opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0], imm = [15:0], target = [25:0].
- Register file:
  - 32×32 bits; r0 reads 0 and is never written.
  - Write on posedge when `wb_en` and `wb_addr` ≠ 0.
  - Reads are combinational with write-through: if `wb_en` && `wb_addr` == index ≠ 0, the read returns `wb_data` in the same cycle.
- Legal opcodes:
  - 0x00 (R-type), 0x02 J, 0x03 JAL, 0x04 BEQ, 0x05 BNE, 0x08–0x0F (immediate ALU), 0x23 LW, 0x2B SW.
  - Any other opcode sets `except` = 1 and loads a bubble.
- Immediate extension:
  - ANDI/ORI/XORI (0x0C–0x0E): zero-extend.
  - LUI (0x0F): {imm, 16'h0}.
  - All others: sign-extend.
- Destination index:
  - JAL: `ex_rd` = 31.
  - I-type: `ex_rd` = rt.
  - R-type: `ex_rd` = rd.
- Load-use stall:
  - `stall` = `ex_mem_read` && `ex_rt_in` ≠ 0 && (`ex_rt_in` == rs || `ex_rt_in` == rt).
  - While stalling: `hold_pc` = `hold_if` = `stall`, and ID/EX loads a bubble.
- Branch/jump (only when !`stall`):
  - BEQ: `br` = (rs_data == rt_data). BNE: `br` = (rs_data != rt_data).
  - BEQ/BNE target: `pc_branch` = `pc_in` + (sext(imm) << 2).
  - J/JAL: `br` = 1, `pc_branch` = {`pc_in`[31:28], target, 2'b00}.
  - Otherwise `br` = 0 and `pc_branch` = 0.
- Branch delay slot: no flush; the instruction already in IF/ID proceeds.
- JAL link value: `ex_imm` = `pc_in` + 4.
- Bubble: `ex_valid` = 0 and all other ID/EX outputs 0. Bubble takes priority over normal load.
- Normal load: `ex_valid` = 1 and all fields from the current instruction.

## Timing
- Reset (async, `rst_n` = 0):
  - All regfile entries = 0, `ex_valid` = 0, `ex_pc` = `RESET_PC`, all other ID/EX outputs = 0.
  - Takes effect immediately, including mid-stall or mid-branch.
- `hold_*`, `br`, `pc_branch` and `except` are combinational from the same-cycle `inst_in`, `ex_*` inputs and regfile reads.
- ID/EX latency: 1 cycle from `inst_in` to the `ex_*` outputs.
- Stall duration: one cycle per load-use hazard. The next cycle's `ex_mem_read` is 0 (bubble in EX), so the held instruction then issues.
- Simultaneous events:
  - Stall + branch: `br` = 0 until the stall clears.
  - Stall + illegal opcode: `except` = 0 until the stall clears.
  - Write-back + read of the same register: bypassed value is used, including for the branch compare.
  - Write to r0: ignored.
- Instruction 0x0000_0000 (SLL r0) is a legal NOP: `ex_valid` = 1, `ex_rd` = 0.

## Test plan
- Reset and write-back:
  - After release, `ex_valid` = 0 and all reads return 0.
  - Write r5 = 0x1234_5678, then decode `add r3,r5,r0` → `ex_rs_data` = 0x1234_5678 one cycle later.
- Write-through and r0:
  - `wb_en`=1, `wb_addr`=8, `wb_data`=0xAA in the same cycle as decode of `or r1,r8,r0` → `ex_rs_data` = 0xAA.
  - Write to r0 → r0 still reads 0.
- Load-use:
  - `ex_mem_read`=1, `ex_rt_in`=9, `inst_in` = `add r2,r9,r1` → `hold_pc` = `hold_if` = 1 for one cycle and a bubble (`ex_valid` = 0).
  - Next cycle: the `add` issues with `ex_valid` = 1.
- BEQ:
  - r1 = r2 = 7, `pc_in` = 0x100, imm = 0xFFFE → `br` = 1, `pc_branch` = 0x0F8.
  - With r2 = 8 → `br` = 0.
- JAL and extension:
  - JAL target 0x40, `pc_in` = 0x1000_0004 → `pc_branch` = 0x1000_0100, `ex_rd` = 31, `ex_imm` = 0x1000_0008.
  - ORI imm 0x8000 → `ex_imm` = 0x0000_8000.
  - ADDI imm 0x8000 → `ex_imm` = 0xFFFF_8000.
- Illegal opcode and mid-stall reset:
  - Opcode 0x3F → `except` = 1 and a bubble.
  - Assert `rst_n` = 0 during a stall → `hold_*` = 0 (ex inputs driven 0) and all outputs at reset values immediately.
